// File: rtl/frame_streamer.sv
// frame_streamer: streams one frame (or back-to-back frames) of pixels from a
// frame BRAM into the filter pipeline. It tolerates BRAM read latency and
// honours downstream backpressure through a credit-counted output FIFO.
module frame_streamer #(
    parameter int PIX_W      = 8,
    parameter int IMG_WIDTH  = 220,
    parameter int IMG_HEIGHT = 168,
    parameter int ADDR_WIDTH = 16,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  stop,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [PIX_W-1:0]      rd_data,
    output logic [PIX_W-1:0]      pixel_out,
    output logic                  pixel_valid,
    input  logic                  pixel_ready,
    output logic                  frame_start,
    output logic                  line_end,
    output logic                  frame_end
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [PW-1:0] P_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]   DEPTH  = (CW + 1)'(FIFO_DEPTH);

    // The FIFO must absorb every read already in flight plus the entry on display.
    generate
        if (FIFO_DEPTH < RD_LAT + 2 || RD_LAT < 1 || RD_LAT > 4) begin : g_bad_cfg
            $error("frame_streamer: need 1<=RD_LAT<=4 and FIFO_DEPTH >= RD_LAT+2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, ABORT} state_t;
    typedef struct packed {
        logic [PIX_W-1:0] pix;
        logic             fs;
        logic             le;
        logic             fe;
    } entry_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   base_q, addr;
    logic                    cont_q, stop_pend;
    logic [XW-1:0]           x;
    logic [YW-1:0]           y;
    logic [CW-1:0]           inflight, count;
    logic [PW-1:0]           rd_ptr, wr_ptr;
    logic [RD_LAT:1]         vld_sr;
    logic [RD_LAT:0]         vld_pipe;
    logic [RD_LAT:1][2:0]    sb_sr;
    logic [RD_LAT:0][2:0]    sb_pipe;
    entry_t                  mem [FIFO_DEPTH];
    logic                    empty, push, pop, abort_go, last_px, room, go;
    logic [2:0]              sb_issue;
    logic [CW:0]             occ;

    assign empty    = (count == '0);
    assign pop      = !empty && pixel_ready;
    assign abort_go = abort && (state != IDLE);
    assign go       = (state == IDLE) && start && !abort;
    // Data returning during or into an abort is dropped on the floor.
    assign push     = vld_pipe[RD_LAT] && (state != ABORT) && !abort_go;
    // Credits: FIFO entries plus outstanding reads, less the one leaving now.
    assign occ      = {1'b0, count} + {1'b0, inflight} - {{CW{1'b0}}, pop};
    assign room     = occ < DEPTH;
    assign last_px  = (x == X_LAST) && (y == Y_LAST);
    assign sb_issue = {(x == '0) && (y == '0), x == X_LAST, last_px};
    assign vld_pipe = {vld_sr, rd_en};
    assign sb_pipe  = {sb_sr, sb_issue};

    assign busy        = (state != IDLE);
    assign rd_addr     = addr;
    assign pixel_valid = !empty;
    assign pixel_out   = empty ? '0 : mem[rd_ptr].pix;
    assign frame_start = !empty && mem[rd_ptr].fs;
    assign line_end    = !empty && mem[rd_ptr].le;
    assign frame_end   = !empty && mem[rd_ptr].fe;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, read issue and done pulse.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (go) state_nxt = RUN;
            RUN: begin
                if (abort) state_nxt = ABORT;
                else if (room) begin
                    rd_en = 1'b1;
                    if (last_px && (!cont_q || stop_pend || stop)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) state_nxt = ABORT;
                else if (inflight == '0 && empty) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            ABORT:   if (inflight == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Run configuration, raster position and incremental read address.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            addr      <= '0;
            cont_q    <= 1'b0;
            stop_pend <= 1'b0;
            x         <= '0;
            y         <= '0;
        end else if (go) begin
            base_q    <= base_addr;
            addr      <= base_addr;
            cont_q    <= continuous;
            stop_pend <= 1'b0;
            x         <= '0;
            y         <= '0;
        end else if (state == RUN) begin
            if (stop && !abort) stop_pend <= 1'b1;
            if (rd_en) begin
                addr <= last_px ? base_q : addr + 1'b1;
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    // Read-latency shift pipe carrying valid and sideband next to the BRAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr   <= '0;
            sb_sr    <= '0;
            inflight <= '0;
        end else begin
            vld_sr   <= vld_pipe[RD_LAT-1:0];
            sb_sr    <= sb_pipe[RD_LAT-1:0];
            inflight <= inflight + CW'(rd_en) - CW'(vld_sr[RD_LAT]);
        end
    end

    // FIFO storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pix: rd_data, fs: sb_pipe[RD_LAT][2],
                                   le: sb_pipe[RD_LAT][1], fe: sb_pipe[RD_LAT][0]};
    end

    // FIFO pointers and occupancy; abort flushes in one cycle.
    always_ff @(posedge clk) begin
        if (rst || abort_go) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == P_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == P_LAST) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count == CW'(FIFO_DEPTH)))
        else $error("frame_streamer FIFO overflow");

endmodule

// File: tb/tb_frame_streamer.sv
// Bench for frame_streamer: three instances (read latency 1/3/2) on a 4x3
// image, each with a registered BRAM model. A negedge monitor logs reads and
// handshakes; scenarios are checked against a raster model of the frame.
module tb_frame_streamer;
    localparam int W = 4, H = 3, NPX = W * H, ND = 3;
    localparam int LAT[ND] = '{1, 3, 2};
    localparam int DEP[ND] = '{4, 5, 4};

    logic clk = 1'b0, rst;
    always #5 clk = ~clk;

    logic        start[ND], cont[ND], stop[ND], abort[ND], ready[ND];
    logic [15:0] base[ND], rd_addr[ND];
    logic        busy[ND], done[ND], rd_en[ND], pv[ND], fs[ND], le[ND], fe[ND];
    logic [7:0]  rd_data[ND], pix[ND];

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_f(logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < ND; g++) begin : g_dut
        logic [7:0] q[4];
        frame_streamer #(.PIX_W(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(16),
                         .RD_LAT(LAT[g]), .FIFO_DEPTH(DEP[g])) dut (
            .clk(clk), .rst(rst), .start(start[g]), .continuous(cont[g]),
            .stop(stop[g]), .abort(abort[g]), .base_addr(base[g]), .busy(busy[g]),
            .done(done[g]), .rd_en(rd_en[g]), .rd_addr(rd_addr[g]),
            .rd_data(rd_data[g]), .pixel_out(pix[g]), .pixel_valid(pv[g]),
            .pixel_ready(ready[g]), .frame_start(fs[g]), .line_end(le[g]),
            .frame_end(fe[g]));
        // BRAM: registered read followed by LAT-1 extra delay stages.
        always @(posedge clk) begin
            q[0] <= mem_f(rd_addr[g]);
            for (int k = 1; k < 4; k++) q[k] <= q[k-1];
        end
        assign rd_data[g] = q[LAT[g]-1];
    end

    // Monitor state (per instance).
    int          iss_n[ND], hs_n[ND], done_n[ND], late_iss[ND];
    int          first_iss[ND], last_iss[ND], first_pv[ND], last_hs[ND], done_cyc[ND];
    bit          aborted[ND];
    logic [15:0] addr_q[ND][$];
    logic [10:0] px_q[ND][$];
    logic        pv_d[ND], rdy_d[ND], ab_d[ND], rst_d[ND];
    logic [10:0] out_d[ND];

    initial forever begin
        @(negedge clk);
        for (int g = 0; g < ND; g++) begin
            if (rd_en[g] === 1'b1) begin
                if (iss_n[g] == 0) first_iss[g] = cyc;
                last_iss[g] = cyc;
                if (aborted[g]) late_iss[g]++;
                else chk("issue_credit", int'((iss_n[g] - hs_n[g] - int'(pv[g] && ready[g])) < DEP[g]), 1);
                addr_q[g].push_back(rd_addr[g]);
                iss_n[g]++;
            end
            if (pv[g] === 1'b1 && first_pv[g] < 0) first_pv[g] = cyc;
            if (pv_d[g] === 1'b1 && rdy_d[g] === 1'b0 && ab_d[g] === 1'b0 && rst_d[g] === 1'b0) begin
                chk("hold_valid", int'(pv[g]), 1);
                chk("hold_data", int'({pix[g], fs[g], le[g], fe[g]}), int'(out_d[g]));
            end
            if (pv[g] === 1'b1 && ready[g] === 1'b1) begin
                px_q[g].push_back({pix[g], fs[g], le[g], fe[g]});
                hs_n[g]++;
                last_hs[g] = cyc;
            end
            if (done[g] === 1'b1) begin
                done_n[g]++;
                done_cyc[g] = cyc;
            end
            pv_d[g] = pv[g]; rdy_d[g] = ready[g]; ab_d[g] = abort[g]; rst_d[g] = rst;
            out_d[g] = {pix[g], fs[g], le[g], fe[g]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr(int d);
        iss_n[d] = 0; hs_n[d] = 0; done_n[d] = 0; late_iss[d] = 0;
        first_iss[d] = -1; last_iss[d] = -1; first_pv[d] = -1;
        last_hs[d] = -1; done_cyc[d] = -1; aborted[d] = 0;
        addr_q[d].delete(); px_q[d].delete();
    endtask

    // mode: 0 ready=1, 1 ready pattern 1-0-0-1, 2 random ready.
    typedef struct {
        int          d;
        logic [15:0] base;
        bit          rnd_base;
        bit          cont;
        int          mode;
        int          stop_at;    // issue index at which stop is raised (-1 none)
        bit          mid_start;  // pulse start (with a different base) mid-run
        int          exp_frames;
        int          exp_done;
    } scn_t;

    task automatic run_scn(scn_t s);
        logic [15:0] b, a;
        logic [10:0] e;
        int t, start_c, n, d;
        d = s.d;
        b = s.rnd_base ? 16'($urandom) : s.base;
        n = s.exp_frames * NPX;
        t = 0;
        clr(d);
        base[d] = b; cont[d] = s.cont; start[d] = 1'b1; ready[d] = 1'b1;
        start_c = cyc;
        tick();
        start[d] = 1'b0;
        while (t < 2000 && done_n[d] == 0) begin
            case (s.mode)
                0:       ready[d] = 1'b1;
                1:       ready[d] = (t % 4 == 0) || (t % 4 == 3);
                default: ready[d] = ($urandom % 3) != 0;
            endcase
            stop[d]  = (s.stop_at >= 0) && (iss_n[d] == s.stop_at);
            start[d] = s.mid_start && (iss_n[d] == 5);
            base[d]  = start[d] ? ~b : b;
            tick();
            t++;
        end
        stop[d] = 1'b0; start[d] = 1'b0; ready[d] = 1'b1;
        tick(); tick();
        chk("timeout", int'(t < 2000), 1);
        chk("n_reads", iss_n[d], n);
        chk("n_pixels", hs_n[d], n);
        chk("done_pulses", done_n[d], s.exp_done);
        chk("busy_after", int'(busy[d]), 0);
        chk("done_after_last_hs", done_cyc[d], last_hs[d] + 1);
        for (int k = 0; k < n && k < addr_q[d].size() && k < px_q[d].size(); k++) begin
            a = b + 16'(k % NPX);
            e = {mem_f(a), (k % NPX) == 0, (k % W) == W - 1, (k % NPX) == NPX - 1};
            chk($sformatf("addr[%0d]", k), int'(addr_q[d][k]), int'(a));
            chk($sformatf("pixel[%0d]", k), int'(px_q[d][k]), int'(e));
        end
        if (s.mode == 0) begin
            chk("first_read_cycle", first_iss[d], start_c + 1);
            chk("first_valid_cycle", first_pv[d], start_c + LAT[d] + 2);
            chk("no_bubble", last_iss[d] - first_iss[d], n - 1);
        end
    endtask

    scn_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 16'h0100, 0, 0, 0, -1, 0, 1, 1};  // single shot, latency 1
        tbl[1] = '{1, 16'h0200, 0, 0, 1, -1, 0, 1, 1};  // latency 3, ready 1001
        tbl[2] = '{1, 16'h0000, 1, 0, 2, -1, 0, 1, 1};  // latency 3, random
        tbl[3] = '{0, 16'h0300, 0, 1, 0, 17, 0, 2, 1};  // continuous, stop in frame 2
        tbl[4] = '{0, 16'hFFFA, 0, 0, 0, -1, 1, 1, 1};  // wrap + ignored start
        tbl[5] = '{2, 16'h0000, 1, 1, 2, 3, 0, 1, 1};   // continuous, early stop

        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            start[d] = 0; cont[d] = 0; stop[d] = 0; abort[d] = 0; ready[d] = 0;
            base[d] = '0;
            clr(d);
        end
        tick(); tick(); tick();
        @(negedge clk);
        for (int d = 0; d < ND; d++)
            chk("reset_outputs", int'({busy[d], done[d], rd_en[d], pv[d], fs[d], le[d],
                                       fe[d], rd_addr[d], pix[d]}), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_scn(tbl[i]);
        chk("wrap_to_zero", int'(addr_q[0][6]), 0);

        // Abort after 6 pixels with backpressure, then a clean restart.
        begin
            int t;
            clr(2);
            base[2] = 16'h0400; cont[2] = 1'b0; ready[2] = 1'b1; start[2] = 1'b1;
            tick();
            start[2] = 1'b0;
            t = 0;
            while (hs_n[2] < 6 && t < 200) begin tick(); t++; end
            chk("abort_reach", int'(t < 200), 1);
            ready[2] = 1'b0; abort[2] = 1'b1;
            tick();
            abort[2] = 1'b0; aborted[2] = 1;
            @(negedge clk);
            chk("abort_valid_low", int'(pv[2]), 0);
            t = 0;
            while (busy[2] && t < 20) begin tick(); t++; end
            tick(); tick();
            chk("abort_idle", int'(busy[2]), 0);
            chk("abort_no_reads", late_iss[2], 0);
            chk("abort_no_done", done_n[2], 0);
            run_scn('{2, 16'h0400, 0, 0, 0, -1, 0, 1, 1});
        end

        // Reset in the middle of a frame clears every output next cycle.
        begin
            int t;
            clr(0);
            base[0] = 16'h0500; cont[0] = 1'b1; ready[0] = 1'b1; start[0] = 1'b1;
            tick();
            start[0] = 1'b0;
            t = 0;
            while (iss_n[0] < 5 && t < 100) begin tick(); t++; end
            rst = 1'b1;
            tick();
            @(negedge clk);
            chk("midrun_reset_outputs", int'({busy[0], done[0], rd_en[0], pv[0], fs[0],
                                              le[0], fe[0], rd_addr[0], pix[0]}), 0);
            rst = 1'b0; cont[0] = 1'b0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
